// File: rtl/snn_spike_pattern_player.sv
// Spike-pattern buffer: host loads per-timestep batch words, playback reassembles
// them into full-width spike vectors and presents one timestep per valid/ready handshake.
module snn_spike_pattern_player #(
    parameter int NUM_INPUTS         = 784,
    parameter int SPIKES_PER_BATCH   = 32,
    parameter int MAX_TIMESTEPS_BITS = 7,
    localparam int NB         = (NUM_INPUTS + SPIKES_PER_BATCH - 1) / SPIKES_PER_BATCH,
    localparam int BATCH_BITS = (NB > 1) ? $clog2(NB) : 1
) (
    input  logic                          S_AXI_ACLK,
    input  logic                          S_AXI_ARESETN,
    input  logic                          wr_en,
    input  logic [MAX_TIMESTEPS_BITS-1:0] wr_timestep,
    input  logic [BATCH_BITS-1:0]         wr_batch,
    input  logic [SPIKES_PER_BATCH-1:0]   wr_data,
    output logic                          wr_err,
    input  logic                          rd_en,
    input  logic [MAX_TIMESTEPS_BITS-1:0] rd_timestep,
    input  logic [BATCH_BITS-1:0]         rd_batch,
    output logic [SPIKES_PER_BATCH-1:0]   rd_data,
    output logic                          rd_valid,
    input  logic                          start,
    input  logic                          abort,
    input  logic                          loop_mode,
    input  logic [MAX_TIMESTEPS_BITS:0]   sim_time,
    output logic [NUM_INPUTS-1:0]         spikes,
    output logic                          spikes_valid,
    input  logic                          spikes_ready,
    output logic [MAX_TIMESTEPS_BITS-1:0] timestep,
    output logic                          busy,
    output logic                          done
);
    localparam int DEPTH  = (2 ** MAX_TIMESTEPS_BITS) * NB;
    localparam int ADDR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_FETCH, S_PRESENT, S_DONE} state_t;

    logic [SPIKES_PER_BATCH-1:0]   mem_r [DEPTH];
    state_t                        state_r;
    logic [BATCH_BITS-1:0]         iss_idx_r;
    logic [BATCH_BITS-1:0]         cap_idx_r;
    logic                          iss_act_r;
    logic                          cap_vld_r;
    logic [MAX_TIMESTEPS_BITS-1:0] ts_r;
    logic [MAX_TIMESTEPS_BITS:0]   sim_time_r;
    logic                          loop_r;
    logic [NUM_INPUTS-1:0]         spikes_r;
    logic                          spikes_valid_r;
    logic                          busy_r;
    logic                          done_r;
    logic                          wr_err_r;
    logic                          rd_valid_r;
    logic [SPIKES_PER_BATCH-1:0]   ram_q_r;

    logic                          idle_s;
    logic                          wr_ok_s;
    logic                          host_rd_s;
    logic                          fetch_rd_s;
    logic                          rd_zero_s;
    logic                          last_ts_s;
    logic [ADDR_W-1:0]             wr_addr_s;
    logic [ADDR_W-1:0]             rd_addr_s;

    function automatic logic [ADDR_W-1:0] word_addr(input logic [MAX_TIMESTEPS_BITS-1:0] ts,
                                                    input logic [BATCH_BITS-1:0] b);
        return ADDR_W'(ts) * ADDR_W'(NB) + ADDR_W'(b);
    endfunction

    // Access qualification and address generation
    always_comb begin
        idle_s     = (state_r == S_IDLE);
        wr_ok_s    = wr_en && idle_s && (int'(wr_batch) < NB);
        host_rd_s  = rd_en && idle_s;
        fetch_rd_s = (state_r == S_FETCH) && iss_act_r;
        rd_zero_s  = !fetch_rd_s && (int'(rd_batch) >= NB);
        wr_addr_s  = word_addr(wr_timestep, wr_batch);
        if (fetch_rd_s) begin
            rd_addr_s = word_addr(ts_r, iss_idx_r);
        end else begin
            rd_addr_s = word_addr(rd_timestep, rd_batch);
        end
        last_ts_s  = ({1'b0, ts_r} == (sim_time_r - {{MAX_TIMESTEPS_BITS{1'b0}}, 1'b1}));
    end

    // Pattern storage; contents deliberately survive reset
    always_ff @(posedge S_AXI_ACLK) begin
        if (wr_ok_s) begin
            mem_r[wr_addr_s] <= wr_data;
        end
    end

    // Registered read port shared by host read-back and playback fetch
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            ram_q_r    <= '0;
            rd_valid_r <= 1'b0;
            wr_err_r   <= 1'b0;
        end else begin
            rd_valid_r <= host_rd_s;
            wr_err_r   <= wr_en && !wr_ok_s;
            if (fetch_rd_s || host_rd_s) begin
                ram_q_r <= rd_zero_s ? '0 : mem_r[rd_addr_s];
            end
        end
    end

    // Playback sequencer: fetch NB words, present the vector, advance or finish
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            state_r        <= S_IDLE;
            iss_idx_r      <= '0;
            cap_idx_r      <= '0;
            iss_act_r      <= 1'b0;
            cap_vld_r      <= 1'b0;
            ts_r           <= '0;
            sim_time_r     <= '0;
            loop_r         <= 1'b0;
            spikes_r       <= '0;
            spikes_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else if (abort) begin
            state_r        <= S_IDLE;
            iss_act_r      <= 1'b0;
            cap_vld_r      <= 1'b0;
            ts_r           <= '0;
            spikes_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            done_r         <= 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        sim_time_r <= sim_time;
                        loop_r     <= loop_mode;
                        busy_r     <= 1'b1;
                        ts_r       <= '0;
                        if (sim_time == '0) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= S_FETCH;
                            iss_idx_r <= '0;
                            iss_act_r <= 1'b1;
                            cap_vld_r <= 1'b0;
                        end
                    end
                end
                S_FETCH: begin
                    cap_vld_r <= iss_act_r;
                    cap_idx_r <= iss_idx_r;
                    if (iss_act_r) begin
                        if (int'(iss_idx_r) == NB - 1) begin
                            iss_act_r <= 1'b0;
                        end else begin
                            iss_idx_r <= iss_idx_r + 1'b1;
                        end
                    end
                    // Padding bits of the last batch have no destination and fall away
                    if (cap_vld_r) begin
                        for (int i = 0; i < NUM_INPUTS; i++) begin
                            if (i / SPIKES_PER_BATCH == int'(cap_idx_r)) begin
                                spikes_r[i] <= ram_q_r[i % SPIKES_PER_BATCH];
                            end
                        end
                        if (int'(cap_idx_r) == NB - 1) begin
                            state_r        <= S_PRESENT;
                            spikes_valid_r <= 1'b1;
                        end
                    end
                end
                S_PRESENT: begin
                    if (spikes_ready) begin
                        spikes_valid_r <= 1'b0;
                        if (last_ts_s && !loop_r) begin
                            state_r <= S_DONE;
                            done_r  <= 1'b1;
                        end else begin
                            state_r   <= S_FETCH;
                            iss_idx_r <= '0;
                            iss_act_r <= 1'b1;
                            cap_vld_r <= 1'b0;
                            ts_r      <= last_ts_s ? '0 : ts_r + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    state_r <= S_IDLE;
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r        <= S_IDLE;
                    spikes_valid_r <= 1'b0;
                    busy_r         <= 1'b0;
                    done_r         <= 1'b0;
                end
            endcase
        end
    end

    assign wr_err       = wr_err_r;
    assign rd_data      = ram_q_r;
    assign rd_valid     = rd_valid_r;
    assign spikes       = spikes_r;
    assign spikes_valid = spikes_valid_r;
    assign timestep     = ts_r;
    assign busy         = busy_r;
    assign done         = done_r;

endmodule
